// File: rtl/pow_n_pkg.sv
// Shared constants for the arg^N stall-capable pipeline: overflow modes and legal exponent range.
package pow_n_pkg;
    localparam int POW_TRUNC = 0;
    localparam int POW_SAT   = 1;

    localparam int POW_N_MIN = 2;
    localparam int POW_N_MAX = 16;
endpackage

// File: rtl/pow_n_stage.sv
// One multiply stage (stages 2..N): p_k = p_(k-1)*a_(k-1) with sticky overflow; 1 cycle per stage.
// Holds its item while downstream is full; loads whenever empty or draining (bubble collapse).
module pow_n_stage
    import pow_n_pkg::*;
#(
    parameter int W   = 8,
    parameter int SAT = POW_TRUNC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         up_vld_i,
    input  logic [W-1:0] up_arg_i,
    input  logic [W-1:0] up_pw_i,
    input  logic         up_ovf_i,
    input  logic         dn_rdy_i,
    output logic         in_rdy_o,
    output logic         vld_o,
    output logic [W-1:0] arg_o,
    output logic [W-1:0] pw_o,
    output logic         ovf_o
);
    logic           vld_q;
    logic           ovf_q;
    logic           ovf_d;
    logic [W-1:0]   arg_q;
    logic [W-1:0]   pw_q;
    logic [W-1:0]   pw_d;
    logic [2*W-1:0] prod;
    logic           load;

    assign in_rdy_o = ~vld_q | dn_rdy_i;
    assign load     = in_rdy_o & ~flush_i;

    always_comb begin
        prod  = {{W{1'b0}}, up_pw_i} * {{W{1'b0}}, up_arg_i};
        ovf_d = up_ovf_i | (|prod[2*W-1:W]);
        pw_d  = prod[W-1:0];
        if (SAT == POW_SAT && ovf_d) begin
            pw_d = '1;
        end
    end

    // Overflow follows valid so an empty stage never reports a stale flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (in_rdy_o) begin
            vld_q <= up_vld_i;
            ovf_q <= up_vld_i & ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load && up_vld_i) begin
            arg_q <= up_arg_i;
            pw_q  <= pw_d;
        end
    end

    assign vld_o = vld_q;
    assign arg_o = arg_q;
    assign pw_o  = pw_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/pow_n_pipe_stall.sv
// arg^N through N handshaked stages; N cycles latency, 1 result/cycle, up to N items in flight.
// Ready ripples back from res_rdy so empty stages keep filling while the output is stalled.
module pow_n_pipe_stall
    import pow_n_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 5,
    parameter int SAT = POW_TRUNC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         arg_vld,
    output logic         arg_rdy,
    input  logic [W-1:0] arg,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic [W-1:0] res,
    output logic         res_ovf,
    output logic [N-1:0] stage_vld
);
    if (N < POW_N_MIN || N > POW_N_MAX) begin : g_bad_n
        $error("pow_n_pipe_stall: N out of legal range");
    end

    logic [N-1:0] vld_s;
    logic [N-1:0] ovf_s;
    logic [N-1:0] in_rdy_s;
    logic [N-1:0] out_rdy_s;
    logic [W-1:0] arg_s [N];
    logic [W-1:0] pw_s  [N];
    logic         v1_q;
    logic [W-1:0] a1_q;
    logic [W-1:0] unused_last_arg;

    // Stage 1 only captures: partial power equals the argument, no overflow yet.
    assign in_rdy_s[0] = ~v1_q | out_rdy_s[0];
    assign arg_rdy     = in_rdy_s[0] & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
        end else if (in_rdy_s[0]) begin
            v1_q <= arg_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (arg_vld && arg_rdy) begin
            a1_q <= arg;
        end
    end

    assign vld_s[0] = v1_q;
    assign arg_s[0] = a1_q;
    assign pw_s[0]  = a1_q;
    assign ovf_s[0] = 1'b0;

    for (genvar k = 0; k < N; k++) begin : g_rdy
        if (k == N - 1) begin : g_last
            assign out_rdy_s[k] = res_rdy;
        end else begin : g_mid
            assign out_rdy_s[k] = in_rdy_s[k+1];
        end
    end

    for (genvar k = 1; k < N; k++) begin : g_stage
        pow_n_stage #(
            .W   (W),
            .SAT (SAT)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush_i  (flush),
            .up_vld_i (vld_s[k-1]),
            .up_arg_i (arg_s[k-1]),
            .up_pw_i  (pw_s[k-1]),
            .up_ovf_i (ovf_s[k-1]),
            .dn_rdy_i (out_rdy_s[k]),
            .in_rdy_o (in_rdy_s[k]),
            .vld_o    (vld_s[k]),
            .arg_o    (arg_s[k]),
            .pw_o     (pw_s[k]),
            .ovf_o    (ovf_s[k])
        );
    end

    // The final stage's argument copy has no consumer and is trimmed in synthesis.
    assign unused_last_arg = arg_s[N-1];

    assign res_vld   = vld_s[N-1];
    assign res       = pw_s[N-1];
    assign res_ovf   = ovf_s[N-1];
    assign stage_vld = vld_s;
endmodule

// File: tb/tb_pow_n_pipe_stall.sv
// Bench for pow_n_pipe_stall: truncating and saturating instances share all inputs.
module tb_pow_n_pipe_stall;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       arg_vld = 1'b0;
    logic [7:0] arg = 8'd0;
    logic       res_rdy = 1'b1;

    logic       arg_rdy0, res_vld0, ovf0;
    logic [7:0] res0;
    logic [4:0] sv0;
    logic       arg_rdy1, res_vld1, ovf1;
    logic [7:0] res1;
    logic [4:0] sv1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] r0;
        logic [7:0] r1;
        logic       ovf;
        logic [7:0] a;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pow_n_pipe_stall #(.W(8), .N(5), .SAT(0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .arg_vld(arg_vld), .arg_rdy(arg_rdy0), .arg(arg),
        .res_vld(res_vld0), .res_rdy(res_rdy), .res(res0),
        .res_ovf(ovf0), .stage_vld(sv0)
    );

    pow_n_pipe_stall #(.W(8), .N(5), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .arg_vld(arg_vld), .arg_rdy(arg_rdy1), .arg(arg),
        .res_vld(res_vld1), .res_rdy(res_rdy), .res(res1),
        .res_ovf(ovf1), .stage_vld(sv1)
    );

    function automatic exp_t model(input logic [7:0] a);
        exp_t m;
        longint unsigned full = 1;
        for (int i = 0; i < 5; i++) full = full * a;
        m.a   = a;
        m.ovf = (full > 255);
        m.r0  = full[7:0];
        m.r1  = m.ovf ? 8'hFF : full[7:0];
        return m;
    endfunction

    // One clock: scoreboard work at the falling edge, then return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (res_vld0 && res_rdy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: res_vld=1 res=%0d with nothing expected", res0);
                end else begin
                    e = q.pop_front();
                    if (res0 !== e.r0 || res1 !== e.r1 || ovf0 !== e.ovf || ovf1 !== e.ovf || res_vld1 !== 1'b1) begin
                        errors++;
                        $display("FAIL sb_result arg=%0d: got trunc=%0d/%b sat=%0d/%b vld1=%b, want trunc=%0d sat=%0d ovf=%b",
                                 e.a, res0, ovf0, res1, ovf1, res_vld1, e.r0, e.r1, e.ovf);
                    end
                end
            end
            if (arg_vld && arg_rdy0) q.push_back(model(arg));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d items still expected, want 0", q.size());
            q.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (res_vld0 !== 1'b0 || res_vld1 !== 1'b0) begin
            errors++; $display("FAIL reset_res_vld: got %b/%b want 0", res_vld0, res_vld1);
        end
        checks++;
        if (sv0 !== 5'b0 || sv1 !== 5'b0) begin
            errors++; $display("FAIL reset_stage_vld: got %b/%b want 00000", sv0, sv1);
        end
        checks++;
        if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL reset_ovf: got %b/%b want 0", ovf0, ovf1);
        end
        checks++;
        if (arg_rdy0 !== 1'b1 || arg_rdy1 !== 1'b1) begin
            errors++; $display("FAIL reset_arg_rdy: got %b/%b want 1", arg_rdy0, arg_rdy1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        res_rdy = 1'b1;
        arg_vld = 1'b1;
        arg = 8'd3;
        tick();
        arg_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sv0 !== 5'(1 << i)) begin
                errors++; $display("FAIL latency_walk step %0d: stage_vld=%b want %b", i, sv0, 5'(1 << i));
            end
            if (i == 4) begin
                checks++;
                if (res_vld0 !== 1'b1 || res0 !== 8'd243 || ovf0 !== 1'b0) begin
                    errors++; $display("FAIL latency_res: vld=%b res=%0d ovf=%b want 1 243 0", res_vld0, res0, ovf0);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [7:0] args [2] = '{8'd4, 8'd2};
        res_rdy = 1'b1;
        foreach (args[i]) begin
            arg_vld = 1'b1;
            arg = args[i];
            tick();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] args [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd255};
        res_rdy = 1'b1;
        foreach (args[i]) begin
            arg_vld = 1'b1;
            arg = args[i];
            checks++;
            if (arg_rdy0 !== 1'b1) begin
                errors++; $display("FAIL b2b_arg_rdy at item %0d: got %b want 1", i, arg_rdy0);
            end
            tick();
        end
        arg_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_vld0 !== 1'b1) begin
                errors++; $display("FAIL b2b_res_vld cycle %0d: got %b want 1", i, res_vld0);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        exp_t head;
        res_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            arg_vld = 1'b1;
            arg = 8'(10 + acc);
            if (arg_rdy0) acc++;
            tick();
        end
        head = model(8'd10);
        checks++;
        if (acc != 5) begin
            errors++; $display("FAIL bp_accepted: got %0d want 5", acc);
        end
        checks++;
        if (arg_rdy0 !== 1'b0 || arg_rdy1 !== 1'b0) begin
            errors++; $display("FAIL bp_arg_rdy: got %b/%b want 0", arg_rdy0, arg_rdy1);
        end
        checks++;
        if (sv0 !== 5'b11111 || sv1 !== 5'b11111) begin
            errors++; $display("FAIL bp_stage_vld: got %b/%b want 11111", sv0, sv1);
        end
        checks++;
        if (res_vld0 !== 1'b1 || res0 !== head.r0 || ovf0 !== head.ovf) begin
            errors++; $display("FAIL bp_res_held: vld=%b res=%0d ovf=%b want 1 %0d %b", res_vld0, res0, ovf0, head.r0, head.ovf);
        end
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_vld0 !== 1'b1) begin
                errors++; $display("FAIL bp_drain_vld cycle %0d: got %b want 1", i, res_vld0);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_bubbles();
        res_rdy = 1'b0;
        arg_vld = 1'b1; arg = 8'd7; tick();
        arg_vld = 1'b0;
        repeat (3) tick();
        arg_vld = 1'b1; arg = 8'd5; tick();
        arg = 8'd6; tick();
        arg_vld = 1'b0;
        repeat (3) tick();
        checks++;
        if (sv0 !== 5'b11100) begin
            errors++; $display("FAIL bubble_compact: stage_vld=%b want 11100", sv0);
        end
        drain();
    endtask

    task automatic test_flush();
        int spur = 0;
        res_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            arg_vld = 1'b1; arg = 8'(20 + i); tick();
        end
        flush = 1'b1;
        arg = 8'd99;
        tick();
        flush = 1'b0;
        arg_vld = 1'b0;
        checks++;
        if (sv0 !== 5'b0 || res_vld0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL flush_clear: stage_vld=%b res_vld=%b ovf=%b want 00000 0 0", sv0, res_vld0, ovf0);
        end
        for (int i = 0; i < 8; i++) begin
            if (res_vld0) spur++;
            tick();
        end
        checks++;
        if (spur != 0) begin
            errors++; $display("FAIL flush_spurious: %0d results after flush want 0", spur);
        end
    endtask

    task automatic test_reset_mid();
        int spur = 0;
        res_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            arg_vld = 1'b1; arg = 8'(30 + i); tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sv0 !== 5'b0 || res_vld0 !== 1'b0 || arg_rdy0 !== 1'b1) begin
            errors++; $display("FAIL async_reset: stage_vld=%b res_vld=%b arg_rdy=%b want 00000 0 1", sv0, res_vld0, arg_rdy0);
        end
        q.delete();
        arg_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (res_vld0) spur++;
            tick();
        end
        checks++;
        if (spur != 0) begin
            errors++; $display("FAIL reset_spurious: %0d results after reset want 0", spur);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pow_n_pipe_stall.md
Name: pow_n_pipe_stall

Overview:
- Parametrised successor to the 5th-power pipeline: computes arg^N through an N-stage multiply pipeline.
- Replaces the global clock enable with a per-stage valid/ready handshake. Stalls propagate backwards and bubbles collapse, so one stalled result does not freeze upstream stages that are empty.
- Adds an overflow flag with selectable truncate/saturate mode and a synchronous flush.
- Sits between an arg producer and a result consumer in the arithmetic lab datapath.

Parameters:
- W, 8, operand and result width in bits.
- N, 5, exponent and stage count; legal range 2..16.
- SAT, 0, overflow mode. 0 = truncate to the low W bits; 1 = saturate to all-ones.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all stage valids; flush has priority over every handshake.
- arg_vld  in  1  input argument valid.
- arg_rdy  out  1  the pipeline accepts arg this cycle.
- arg  in  W  input argument, unsigned.
- res_vld  out  1  final-stage result valid.
- res_rdy  in  1  the consumer accepts res this cycle.
- res  out  W  arg^N, truncated or saturated per SAT.
- res_ovf  out  1  the true arg^N exceeded 2^W-1.
- stage_vld  out  N  valid bit of each stage; bit 0 = stage 1, bit N-1 = stage N.

Behaviour:
- Reset (async, rst_n=0): every stage valid and every stage overflow bit clears to 0.
  - Outputs during reset: res_vld=0, stage_vld=0, res_ovf=0, arg_rdy=1.
  - Data registers are not reset. res is don't-care while res_vld=0.
- Stage contents:
  - Stage 1 holds {a1=arg, p1=arg, o1=0}.
  - Stage k (2..N) holds {a_k=a_(k-1), p_k=f(p_(k-1)*a_(k-1)), o_k}. a_k is not needed in stage N and may be dropped.
- Product arithmetic: form the full 2W-bit product, then:
  - o_k = o_(k-1) OR (product[2W-1:W] != 0).
  - SAT=0: p_k = product[W-1:0].
  - SAT=1: p_k = all-ones if o_k is set, otherwise product[W-1:0]. Once saturated, stays saturated.
- Outputs: res=p_N, res_ovf=o_N, res_vld=v_N.
- Stage advance rule:
  - adv_N = v_N & res_rdy (output consumed).
  - Stage k (<N) may pass its item down when !v_(k+1) | adv_(k+1).
  - Stage k loads from stage k-1 when that condition holds; v_k' = v_(k-1) in that case.
  - A valid stage that cannot move holds data and valid unchanged.
- arg_rdy = !v_1 | (stage 1 can pass down). An input is accepted when arg_vld & arg_rdy.
- Combinational paths: arg_rdy depends combinationally on res_rdy (ready chain, N gates deep). There is no combinational path arg to res.
- Latency: N cycles from acceptance to res_vld when downstream never stalls. Throughput is 1 per cycle.
- Capacity: up to N items in flight. A full pipeline with res_rdy=0 gives arg_rdy=0.
- Bubble collapse: with res_rdy=0, new items keep being accepted until all N stages are valid.
- flush=1: all v_k and o_k clear next edge. Input arg is ignored that cycle and not accepted. Outputs next cycle match reset values.
- Simultaneous pop at stage N and push at stage 1 in the same cycle is legal and keeps occupancy constant.
- Data stability: res and res_ovf stay stable while res_vld=1 and res_rdy=0.
- Reset mid-operation discards all in-flight items. No partial result is ever presented.

Decomposition:
- Package pow_n_pkg holds:
  - the SAT mode constants (POW_TRUNC=0, POW_SAT=1);
  - the legal N range constants, checked by an elaboration-time guard.
- Natural sub-module pow_n_stage, instantiated N-1 times via generate for stages 2..N:
  - parameters W, SAT;
  - holds valid, arg, partial power, ovf registers;
  - contains the advance logic and multiply/overflow combinational logic.
- Stage 1 is a plain capture stage in the top level.

Test Plan:
- W=8, N=5, SAT=0, res_rdy=1; arg=3 accepted at cycle 0 -> res_vld=1 at cycle 5, res=243, res_ovf=0. stage_vld walks 00001 to 10000.
- Overflow: arg=4 -> SAT=0 gives res=0x00, res_ovf=1 (1024 mod 256). SAT=1 gives res=0xFF, res_ovf=1. arg=2 (32) gives ovf=0 in both modes.
- Streaming: args 0,1,2,3,255 back-to-back with res_rdy=1 -> results 0,1,32,243,255 (SAT=0, ovf=1 for 255) on consecutive cycles. arg_rdy stays 1 throughout.
- Backpressure and collapse: res_rdy=0, arg_vld=1 for 8 cycles -> exactly 5 accepted, then arg_rdy=0 and stage_vld=11111 with res held stable. Raising res_rdy pops one per cycle in order.
- Bubbles: one item, then 3 idle cycles, then 2 items, with res_rdy=0 -> items compact into stages 5,4,3. Order is preserved on drain.
- Flush with 3 items in flight and arg_vld=1 -> next cycle stage_vld=0, res_vld=0, and the flushed-cycle arg is not emitted. Separately, asserting rst_n=0 mid-stream clears immediately (async), with no spurious res_vld after release.
